// File: rtl/axil_slv_wr_ch.sv
// AXI4-Lite slave write channel: independent 2-deep AW/W queues, in-order pairing,
// window decode onto a word-addressed memory port, and a 2-deep B response queue.

module axil_slv_wr_ch_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = slot_q[rd_ptr_q];

  // Full/empty come from pre-edge occupancy, so a pop never makes room for a same-edge push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= din_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

module axil_slv_wr_ch #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MEM_AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [32:0] BASE33  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT33 = BASE33 + (33'd1 << (MEM_AW + 2));
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic              aw_full, aw_empty;
  logic [31:0]       aw_head;
  logic              w_full, w_empty;
  logic [35:0]       w_head;
  logic              b_full, b_empty;
  logic [1:0]        b_head;
  logic              aw_push, w_push, b_pop;
  logic              commit;
  logic              in_range;
  logic [31:0]       offset;
  logic [1:0]        resp;

  logic              mem_we_q,    mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [15:0]       wr_cnt_q,    wr_cnt_d;
  logic [15:0]       err_cnt_q,   err_cnt_d;

  logic              unused_bits;
  assign unused_bits = ^{s_axi_awprot, offset};

  assign s_axi_awready = !aw_full && !rst;
  assign s_axi_wready  = !w_full && !rst;
  assign aw_push       = s_axi_awvalid && s_axi_awready;
  assign w_push        = s_axi_wvalid && s_axi_wready;
  assign b_pop         = s_axi_bvalid && s_axi_bready;

  // Commit decision uses pre-edge occupancy only; a B pop on the same edge does not free a slot.
  assign commit = !aw_empty && !w_empty && !b_full;

  axil_slv_wr_ch_fifo2 #(.WIDTH(32)) u_aw_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aw_push),
    .pop_i   (commit),
    .din_i   (s_axi_awaddr),
    .dout_o  (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty)
  );

  axil_slv_wr_ch_fifo2 #(.WIDTH(36)) u_w_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (commit),
    .din_i   ({s_axi_wdata, s_axi_wstrb}),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  axil_slv_wr_ch_fifo2 #(.WIDTH(2)) u_b_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (commit),
    .pop_i   (b_pop),
    .din_i   (resp),
    .dout_o  (b_head),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  assign s_axi_bvalid = !b_empty;
  assign s_axi_bresp  = b_head;

  assign in_range = ({1'b0, aw_head} >= BASE33) && ({1'b0, aw_head} < LIMIT33);
  assign offset   = aw_head - ADDR_BASE;
  assign resp     = in_range ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wr_cnt_d    = wr_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (commit) begin
      if (in_range) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = offset[MEM_AW+1:2];
        mem_wdata_d = w_head[35:4];
        mem_wstrb_d = w_head[3:0];
        wr_cnt_d    = wr_cnt_q + 16'd1;
      end else begin
        err_cnt_d   = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wr_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wr_cnt_q    <= wr_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wr_cnt    = wr_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axil_slv_wr_ch.sv
// Directed bench for axil_slv_wr_ch: latency, ordering, decode, back-pressure and reset.

module tb_axil_slv_wr_ch;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] wr_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  logic [9:0] we_log [$];
  logic [1:0] b_log  [$];

  axil_slv_wr_ch #(.ADDR_BASE(BASE), .MEM_AW(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .wr_cnt        (wr_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // Pre-edge values at each rising edge: exact B handshakes and one entry per mem_we pulse.
  always @(posedge clk) begin
    if (mem_we) we_log.push_back(mem_addr);
    if (s_axi_bvalid && s_axi_bready) b_log.push_back(s_axi_bresp);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = a;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = d; s_axi_wstrb = s;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = 3'b010;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++;
      $display("FAIL rst_ready: got aw=%b w=%b expected 0 0", s_axi_awready, s_axi_wready); end
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_bresp !== 2'b00) begin errors++;
      $display("FAIL rst_b: got bvalid=%b bresp=%b expected 0 00", s_axi_bvalid, s_axi_bresp); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin errors++;
      $display("FAIL rst_mem: got we=%b addr=%0h data=%0h strb=%0h expected all 0", mem_we, mem_addr, mem_wdata, mem_wstrb); end
    checks++; if (wr_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++;
      $display("FAIL rst_cnt: got wr=%0d err=%0d expected 0 0", wr_cnt, err_cnt); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin errors++;
      $display("FAIL rst_release_ready: got aw=%b w=%b expected 1 1", s_axi_awready, s_axi_wready); end
  endtask

  task automatic test_single();
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h10;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || s_axi_bvalid !== 1'b0) begin errors++;
      $display("FAIL single_early: got we=%b bvalid=%b expected 0 0", mem_we, s_axi_bvalid); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF) begin errors++;
      $display("FAIL single_mem: got we=%b addr=%0h data=%0h strb=%0h expected 1 4 12345678 f", mem_we, mem_addr, mem_wdata, mem_wstrb); end
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || wr_cnt !== 16'd1) begin errors++;
      $display("FAIL single_b: got bvalid=%b bresp=%b wr=%0d expected 1 00 1", s_axi_bvalid, s_axi_bresp, wr_cnt); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || s_axi_bvalid !== 1'b0 || mem_addr !== 10'd4) begin errors++;
      $display("FAIL single_after: got we=%b bvalid=%b addr=%0h expected 0 0 4", mem_we, s_axi_bvalid, mem_addr); end
  endtask

  task automatic test_w_first();
    tick();
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hAAAA_0001; s_axi_wstrb = 4'hF;
    tick();
    s_axi_wdata = 32'hBBBB_0002; s_axi_wstrb = 4'b0101;
    @(negedge clk);
    checks++; if (s_axi_wready !== 1'b1) begin errors++;
      $display("FAIL wfirst_one_pending: got wready=%b expected 1", s_axi_wready); end
    tick();
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    checks++; if (s_axi_wready !== 1'b0) begin errors++;
      $display("FAIL wfirst_full: got wready=%b expected 0", s_axi_wready); end
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h8;
    tick();
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++;
      $display("FAIL wfirst_early: got we=%b expected 0", mem_we); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd2 || mem_wdata !== 32'hAAAA_0001 || s_axi_wready !== 1'b1) begin errors++;
      $display("FAIL wfirst_commit1: got we=%b addr=%0h data=%0h wready=%b expected 1 2 aaaa0001 1", mem_we, mem_addr, mem_wdata, s_axi_wready); end
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'hC;
    tick();
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd3 || mem_wdata !== 32'hBBBB_0002 || mem_wstrb !== 4'b0101) begin errors++;
      $display("FAIL wfirst_commit2: got we=%b addr=%0h data=%0h strb=%b expected 1 3 bbbb0002 0101", mem_we, mem_addr, mem_wdata, mem_wstrb); end
    checks++; if (wr_cnt !== 16'd3) begin errors++;
      $display("FAIL wfirst_cnt: got wr=%0d expected 3", wr_cnt); end
  endtask

  task automatic test_out_of_range();
    drive_aw_w(BASE + 32'h1000, 32'hDEAD_BEEF, 4'hF);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 10'd3) begin errors++;
      $display("FAIL oor_mem: got we=%b addr=%0h expected 0 3", mem_we, mem_addr); end
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10 || err_cnt !== 16'd1 || wr_cnt !== 16'd3) begin errors++;
      $display("FAIL oor_b: got bvalid=%b bresp=%b err=%0d wr=%0d expected 1 10 1 3", s_axi_bvalid, s_axi_bresp, err_cnt, wr_cnt); end
    drive_aw_w(BASE + 32'hFFC, 32'hCAFE_F00D, 4'b1000);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd1023 || s_axi_bresp !== 2'b00 || wr_cnt !== 16'd4) begin errors++;
      $display("FAIL top_word: got we=%b addr=%0h bresp=%b wr=%0d expected 1 3ff 00 4", mem_we, mem_addr, s_axi_bresp, wr_cnt); end
    drive_aw_w(BASE - 32'h4, 32'h0BAD_0BAD, 4'hF);
    checks++; if (mem_we !== 1'b0 || s_axi_bresp !== 2'b10 || err_cnt !== 16'd2) begin errors++;
      $display("FAIL below_base: got we=%b bresp=%b err=%0d expected 0 10 2", mem_we, s_axi_bresp, err_cnt); end
    drive_aw_w(BASE + 32'h15, 32'h5555_AAAA, 4'b0000);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wstrb !== 4'b0000 || s_axi_bresp !== 2'b00 || wr_cnt !== 16'd5) begin errors++;
      $display("FAIL zero_strb: got we=%b addr=%0h strb=%b bresp=%b wr=%0d expected 1 5 0000 00 5", mem_we, mem_addr, mem_wstrb, s_axi_bresp, wr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic exp_we;
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h100;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h100; s_axi_wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 3) begin
        s_axi_awaddr = BASE + 32'h100 + 32'(4 * (i + 1));
        s_axi_wdata  = 32'h100 + 32'(i + 1);
      end else if (i == 3) begin
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      end
      @(negedge clk);
      exp_we = (i >= 1 && i <= 4);
      checks++; if (mem_we !== exp_we || (exp_we && mem_addr !== 10'(64 + i - 1))) begin errors++;
        $display("FAIL b2b_we[%0d]: got we=%b addr=%0h expected %b %0h", i, mem_we, mem_addr, exp_we, 64 + i - 1); end
      checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin errors++;
        $display("FAIL b2b_ready[%0d]: got aw=%b w=%b expected 1 1", i, s_axi_awready, s_axi_wready); end
    end
    checks++; if (wr_cnt !== 16'd9) begin errors++;
      $display("FAIL b2b_cnt: got wr=%0d expected 9", wr_cnt); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic rdy;
    we_log.delete(); b_log.delete();
    tick();
    s_axi_bready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h40;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hB000_0000; s_axi_wstrb = 4'hF;
    repeat (6) begin
      @(negedge clk);
      rdy = s_axi_awvalid && s_axi_awready && s_axi_wready;
      tick();
      if (rdy) begin
        acc++;
        if (acc < 6) begin
          s_axi_awaddr = BASE + 32'h40 + 32'(4 * acc);
          s_axi_wdata  = 32'hB000_0000 + 32'(acc);
        end else begin
          s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end
      end
    end
    @(negedge clk);
    checks++; if (acc !== 4 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++;
      $display("FAIL bp_stall: got accepted=%0d aw=%b w=%b expected 4 0 0", acc, s_axi_awready, s_axi_wready); end
    checks++; if (we_log.size() !== 2 || wr_cnt !== 16'd11 || s_axi_bvalid !== 1'b1 || mem_we !== 1'b0) begin errors++;
      $display("FAIL bp_commits: got pulses=%0d wr=%0d bvalid=%b we=%b expected 2 11 1 0", we_log.size(), wr_cnt, s_axi_bvalid, mem_we); end
    s_axi_bready = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || s_axi_bvalid !== 1'b1) begin errors++;
      $display("FAIL bp_full_pop: got we=%b bvalid=%b expected 0 1", mem_we, s_axi_bvalid); end
    for (int cy = 0; cy < 60 && (acc < 6 || b_log.size() < 6); cy++) begin
      rdy = s_axi_awvalid && s_axi_awready && s_axi_wready;
      tick();
      if (rdy) begin
        acc++;
        if (acc < 6) begin
          s_axi_awaddr = BASE + 32'h40 + 32'(4 * acc);
          s_axi_wdata  = 32'hB000_0000 + 32'(acc);
        end else begin
          s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end
      end
      @(negedge clk);
    end
    checks++; if (b_log.size() !== 6 || we_log.size() !== 6) begin errors++;
      $display("FAIL bp_drain: got responses=%0d pulses=%0d expected 6 6", b_log.size(), we_log.size()); end
    for (int i = 0; i < 6 && i < we_log.size() && i < b_log.size(); i++) begin
      checks++; if (we_log[i] !== 10'(16 + i) || b_log[i] !== 2'b00) begin errors++;
        $display("FAIL bp_order[%0d]: got addr=%0h resp=%b expected %0h 00", i, we_log[i], b_log[i], 16 + i); end
    end
    checks++; if (wr_cnt !== 16'd15 || s_axi_bvalid !== 1'b0) begin errors++;
      $display("FAIL bp_end: got wr=%0d bvalid=%b expected 15 0", wr_cnt, s_axi_bvalid); end
  endtask

  task automatic test_reset_mid();
    s_axi_bready = 1'b0;
    drive_aw_w(BASE + 32'h80, 32'h1111_2222, 4'hF);
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h84;
    tick();
    s_axi_awaddr = BASE + 32'h88;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h3333_4444; s_axi_wstrb = 4'hF;
    tick();
    s_axi_wvalid = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b1 || wr_cnt !== 16'd16 || s_axi_awready !== 1'b0) begin errors++;
      $display("FAIL mid_prestate: got bvalid=%b wr=%0d awready=%b expected 1 16 0", s_axi_bvalid, wr_cnt, s_axi_awready); end
    rst = 1'b1;
    #1;
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++;
      $display("FAIL mid_rst_out: got bvalid=%b aw=%b w=%b expected 0 0 0", s_axi_bvalid, s_axi_awready, s_axi_wready); end
    checks++; if (wr_cnt !== 16'd0 || err_cnt !== 16'd0 || mem_addr !== 10'd0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL mid_rst_regs: got wr=%0d err=%0d addr=%0h we=%b expected 0 0 0 0", wr_cnt, err_cnt, mem_addr, mem_we); end
    we_log.delete(); b_log.delete();
    s_axi_bready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_bvalid !== 1'b0) begin errors++;
      $display("FAIL mid_release: got aw=%b w=%b bvalid=%b expected 1 1 0", s_axi_awready, s_axi_wready, s_axi_bvalid); end
    repeat (4) tick();
    @(negedge clk);
    checks++; if (we_log.size() !== 0 || b_log.size() !== 0 || wr_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++;
      $display("FAIL mid_discard: got pulses=%0d responses=%0d wr=%0d err=%0d expected 0 0 0 0", we_log.size(), b_log.size(), wr_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_w_first();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1);
  end

endmodule
